// File: rtl/spi_frame_rx_pkg.sv
// Shared constants and types for the SPI frame receiver.
// Frame layout (MSB first): [15] rw, [14:8] address, [7:0] data.
package spi_frame_pkg;

    // Default frame geometry; ADDR_W + DATA_W + 1 must equal FRAME_BITS.
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_ADDR_W     = 7;
    localparam int DEF_DATA_W     = 8;

    // Field bit positions inside the default 16-bit frame.
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

    // Receiver state: waiting for chip select, or collecting bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/spi_frame_rx_if.sv
// Decoded-frame bus from the SPI receiver to the register bank.
// master = receiver (drives fields and strobes), slave = register bank.
interface spi_frame_rx_if
    import spi_frame_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              frame_valid;
    logic              frame_rw;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic              frame_err;
    logic              busy;

    modport master (
        output frame_valid,
        output frame_rw,
        output frame_addr,
        output frame_data,
        output frame_err,
        output busy
    );

    modport slave (
        input frame_valid,
        input frame_rw,
        input frame_addr,
        input frame_data,
        input frame_err,
        input busy
    );

endinterface

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, plus a history flop
// so that rising/falling edges of the synchronised value can be detected.
// RST_VAL is the idle level of the pin, so no false edge appears after reset.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_reg;
    logic              hist_reg;

    // Shift the raw pin through the synchroniser chain; remember last output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_reg <= {STAGES{RST_VAL}};
            hist_reg  <= RST_VAL;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
            hist_reg  <= chain_reg[STAGES-1];
        end
    end

    assign sync = chain_reg[STAGES-1];
    assign rise = sync & ~hist_reg;
    assign fall = ~sync & hist_reg;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0, MSB-first frame receiver. Pins are synchronised into clk,
// bits are shifted on synchronised SCLK rising edges while nCS is low, and
// the frame is judged when nCS rises: exact length -> fields + valid pulse,
// any other non-zero length -> error pulse, zero bits -> silently ignored.
module spi_frame_rx
    import spi_frame_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = DEF_FRAME_BITS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  copi,
    input  logic                  ncs,
    spi_frame_rx_if.master        frame_bus
);

    // Counter must hold FRAME_BITS+1 so over-length frames stay detectable.
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic sclk_sync;
    logic sclk_rise;
    logic sclk_fall_unused;
    logic copi_sync;
    logic copi_rise_unused;
    logic copi_fall_unused;
    logic ncs_sync;
    logic ncs_rise;
    logic ncs_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sclk),
        .sync  (sclk_sync),
        .rise  (sclk_rise),
        .fall  (sclk_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (copi),
        .sync  (copi_sync),
        .rise  (copi_rise_unused),
        .fall  (copi_fall_unused)
    );

    // nCS idles high, so its synchroniser resets high.
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ncs),
        .sync  (ncs_sync),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    rx_state_t              state_reg,  state_next;
    logic [CNT_W-1:0]       cnt_reg,    cnt_next;
    logic [FRAME_BITS-1:0]  shift_reg,  shift_next;
    logic                   valid_reg,  valid_next;
    logic                   err_reg,    err_next;
    logic                   rw_reg,     rw_next;
    logic [ADDR_W-1:0]      addr_reg,   addr_next;
    logic [DATA_W-1:0]      data_reg,   data_next;

    // State, shifter, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            rw_reg    <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
            rw_reg    <= rw_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
        end
    end

    // Next-state logic: start on nCS fall, shift on SCLK rise, judge on nCS rise.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        valid_next = 1'b0;
        err_next   = 1'b0;
        rw_next    = rw_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;

        case (state_reg)
            IDLE: begin
                if (ncs_fall) begin
                    cnt_next   = '0;
                    shift_next = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    // A coincident SCLK edge is dropped here: nCS is already high.
                    state_next = IDLE;
                    if (cnt_reg == CNT_FULL) begin
                        valid_next = 1'b1;
                        rw_next    = shift_reg[FRAME_BITS-1];
                        addr_next  = shift_reg[FRAME_BITS-2 -: ADDR_W];
                        data_next  = shift_reg[DATA_W-1:0];
                    end else if (cnt_reg != '0) begin
                        err_next = 1'b1;
                    end
                end else if (sclk_rise && !ncs_sync) begin
                    shift_next = {shift_reg[FRAME_BITS-2:0], copi_sync};
                    if (cnt_reg != CNT_SAT) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign frame_bus.frame_valid = valid_reg;
    assign frame_bus.frame_err   = err_reg;
    assign frame_bus.frame_rw    = rw_reg;
    assign frame_bus.frame_addr  = addr_reg;
    assign frame_bus.frame_data  = data_reg;
    assign frame_bus.busy        = ~ncs_sync;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: a table of whole frames with expected
// pulse counts and fields, plus hand-written reset, idle-noise and
// back-to-back sequences. SCLK runs at clk/8.
module tb_spi_frame_rx;

    localparam int SYNC_STAGES = 2;

    logic clk;
    logic rst_n;
    logic sclk;
    logic copi;
    logic ncs;

    spi_frame_rx_if #(.ADDR_W(7), .DATA_W(8)) fbus ();

    spi_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .FRAME_BITS  (16),
        .ADDR_W      (7),
        .DATA_W      (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .copi      (copi),
        .ncs       (ncs),
        .frame_bus (fbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int         valid_cnt = 0;
    int         err_cnt   = 0;
    int         both_cnt  = 0;
    int         consec_cnt = 0;
    logic       prev_pulse = 1'b0;
    logic [7:0] vdata_q[$];
    int         vcyc_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (fbus.frame_valid) begin
                valid_cnt++;
                vdata_q.push_back(fbus.frame_data);
                vcyc_q.push_back(cyc);
            end
            if (fbus.frame_err) err_cnt++;
            if (fbus.frame_valid && fbus.frame_err) both_cnt++;
            if ((fbus.frame_valid || fbus.frame_err) && prev_pulse) consec_cnt++;
            prev_pulse = fbus.frame_valid | fbus.frame_err;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        valid_cnt = 0;
        err_cnt   = 0;
        vdata_q.delete();
        vcyc_q.delete();
    endtask

    // Clock nbits of value out MSB first; COPI settles 4 clk before each rise.
    task automatic send_bits(input logic [31:0] value, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            copi = value[nbits-1-i];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] value, input int nbits, output int rise_cyc);
        ncs = 1'b0;
        wait_clk(4);
        send_bits(value, nbits);
        wait_clk(4);
        ncs = 1'b1;
        rise_cyc = cyc;
    endtask

    typedef struct {
        logic [31:0] value;
        int          nbits;
        int          exp_valid;
        int          exp_err;
        logic        exp_rw;
        logic [6:0]  exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int r0;
        int r1;
        int lat;

        vecs[0] = '{32'h0000_804A, 16, 1, 0, 1'b1, 7'h00, 8'h4A};
        vecs[1] = '{32'h0000_8233, 16, 1, 0, 1'b1, 7'h02, 8'h33};
        vecs[2] = '{32'h0000_0ABC, 12, 0, 1, 1'b1, 7'h02, 8'h33};
        vecs[3] = '{32'h0002_AAAA, 18, 0, 1, 1'b1, 7'h02, 8'h33};
        vecs[4] = '{32'h0000_0000,  0, 0, 0, 1'b1, 7'h02, 8'h33};
        vecs[5] = '{32'h0000_0001,  1, 0, 1, 1'b1, 7'h02, 8'h33};
        vecs[6] = '{32'h0001_FFFF, 17, 0, 1, 1'b1, 7'h02, 8'h33};
        vecs[7] = '{32'h0000_7F55, 16, 1, 0, 1'b0, 7'h7F, 8'h55};

        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        wait_clk(3);

        check("rst_valid", {31'd0, fbus.frame_valid}, 32'd0);
        check("rst_err",   {31'd0, fbus.frame_err},   32'd0);
        check("rst_busy",  {31'd0, fbus.busy},        32'd0);
        check("rst_fields", {16'd0, fbus.frame_rw, fbus.frame_addr, fbus.frame_data}, 32'd0);

        rst_n = 1'b1;
        clear_mon();
        wait_clk(100);
        check("idle_valid_cnt", valid_cnt, 0);
        check("idle_err_cnt",   err_cnt,   0);
        check("idle_busy",      {31'd0, fbus.busy}, 32'd0);

        // Table of whole frames.
        for (int v = 0; v < 8; v++) begin
            clear_mon();
            send_frame(vecs[v].value, vecs[v].nbits, r0);
            wait_clk(10);
            $display("vec %0d: value=0x%0h bits=%0d valid=%0d err=%0d rw=%0b addr=0x%0h data=0x%0h",
                     v, vecs[v].value, vecs[v].nbits, valid_cnt, err_cnt,
                     fbus.frame_rw, fbus.frame_addr, fbus.frame_data);
            check($sformatf("v%0d_valid_cnt", v), valid_cnt, vecs[v].exp_valid);
            check($sformatf("v%0d_err_cnt", v),   err_cnt,   vecs[v].exp_err);
            check($sformatf("v%0d_rw", v),   {31'd0, fbus.frame_rw},   {31'd0, vecs[v].exp_rw});
            check($sformatf("v%0d_addr", v), {25'd0, fbus.frame_addr}, {25'd0, vecs[v].exp_addr});
            check($sformatf("v%0d_data", v), {24'd0, fbus.frame_data}, {24'd0, vecs[v].exp_data});
        end

        // SCLK noise with nCS high must be ignored.
        clear_mon();
        for (int i = 0; i < 20; i++) begin
            copi = i[0];
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
            wait_clk(4);
        end
        wait_clk(10);
        $display("sclk noise: valid=%0d err=%0d", valid_cnt, err_cnt);
        check("noise_valid_cnt", valid_cnt, 0);
        check("noise_err_cnt",   err_cnt,   0);
        check("noise_fields", {16'd0, fbus.frame_rw, fbus.frame_addr, fbus.frame_data}, 32'h0000_7F55);

        // Reset in the middle of 0x81FF, then a clean 0x8104.
        clear_mon();
        ncs = 1'b0;
        wait_clk(4);
        send_bits(32'h0000_0103, 9);
        check("midframe_busy", {31'd0, fbus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   {31'd0, fbus.busy}, 32'd0);
        check("midrst_fields", {16'd0, fbus.frame_rw, fbus.frame_addr, fbus.frame_data}, 32'd0);
        wait_clk(2);
        ncs = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(10);
        check("abort_valid_cnt", valid_cnt, 0);
        check("abort_err_cnt",   err_cnt,   0);
        send_frame(32'h0000_8104, 16, r0);
        wait_clk(10);
        $display("after reset: value=0x8104 valid=%0d err=%0d addr=0x%0h data=0x%0h",
                 valid_cnt, err_cnt, fbus.frame_addr, fbus.frame_data);
        check("post_rst_valid_cnt", valid_cnt, 1);
        check("post_rst_err_cnt",   err_cnt,   0);
        check("post_rst_addr", {25'd0, fbus.frame_addr}, 32'h01);
        check("post_rst_data", {24'd0, fbus.frame_data}, 32'h04);

        // Back-to-back frames with a minimal nCS-high gap.
        clear_mon();
        send_frame(32'h0000_8000, 16, r0);
        wait_clk(SYNC_STAGES + 2);
        send_frame(32'h0000_80FF, 16, r1);
        wait_clk(10);
        $display("b2b: valid=%0d err=%0d", valid_cnt, err_cnt);
        check("b2b_valid_cnt", valid_cnt, 2);
        check("b2b_err_cnt",   err_cnt,   0);
        if (vdata_q.size() == 2 && vcyc_q.size() == 2) begin
            check("b2b_data0", {24'd0, vdata_q[0]}, 32'h00);
            check("b2b_data1", {24'd0, vdata_q[1]}, 32'hFF);
            lat = vcyc_q[0] - r0;
            check($sformatf("b2b_lat0(%0d)_in_range", lat),
                  {31'd0, (lat >= SYNC_STAGES + 1 && lat <= SYNC_STAGES + 3)}, 32'd1);
            lat = vcyc_q[1] - r1;
            check($sformatf("b2b_lat1(%0d)_in_range", lat),
                  {31'd0, (lat >= SYNC_STAGES + 1 && lat <= SYNC_STAGES + 3)}, 32'd1);
        end else begin
            check("b2b_pulse_records", vdata_q.size(), 2);
        end

        check("valid_err_overlap",  both_cnt,   0);
        check("consecutive_pulses", consec_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
